// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: FSM state encoding used by the timers.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer; the controller drives master, the timer is slave.
interface countdown_timer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             reload_en;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output en, load, d, reload_en,
    input  q, tc, busy, done
  );

  modport slave (
    input  en, load, d, reload_en,
    output q, tc, busy, done
  );
endinterface

// File: rtl/down_cnt_core.sv
// Datapath of the countdown timer: count and reload registers with load/decrement/reload mux.
module down_cnt_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             reload_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_is_one
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rl_q, rl_d;

  assign q        = q_q;
  assign q_is_one = (q_q == WIDTH'(1));

  // Load wins over stepping; the terminal step goes to reload or zero, so q never wraps.
  always_comb begin
    q_d  = q_q;
    rl_d = rl_q;
    if (load) begin
      q_d  = d;
      rl_d = d;
    end else if (step) begin
      if (q_is_one) q_d = reload_en ? rl_q : '0;
      else          q_d = q_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q  <= '0;
      rl_q <= '0;
    end else begin
      q_q  <= q_d;
      rl_q <= rl_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle terminal-count pulse and optional auto-reload.
module countdown_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  countdown_timer_if.slave    bus
);
  import counter_pkg::*;

  state_e           state_q, state_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             active;
  logic             step;
  logic             q_is_one;
  logic [WIDTH-1:0] q;

  assign active = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign step   = active && bus.en && !bus.load;

  down_cnt_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (bus.load),
    .step      (step),
    .reload_en (bus.reload_en),
    .d         (bus.d),
    .q         (q),
    .q_is_one  (q_is_one)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      if (bus.d == '0) state_d = ST_DONE;
      else             state_d = bus.en ? ST_RUN : ST_PAUSE;
    end else begin
      case (state_q)
        ST_RUN, ST_PAUSE: begin
          if (!bus.en)                           state_d = ST_PAUSE;
          else if (q_is_one && !bus.reload_en)   state_d = ST_DONE;
          else                                   state_d = ST_RUN;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Status flags are registered from the next state so they line up with q.
  always_comb begin
    tc_d   = step && q_is_one;
    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    done_d = (state_d == ST_DONE);
  end

  assign bus.q    = q;
  assign bus.tc   = tc_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed plus randomized bench for countdown_timer against a behavioural reference model.
module tb_countdown_timer;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst;

  countdown_timer_if #(.WIDTH(W)) bus ();

  countdown_timer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: count value, saved reload value, and status flags.
  int m_q, m_rl;
  bit m_tc, m_busy, m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"},    32'(bus.q),    32'(m_q));
    chk({tag, ".tc"},   32'(bus.tc),   32'(m_tc));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(m_busy));
    chk({tag, ".done"}, 32'(bus.done), 32'(m_done));
  endtask

  task automatic model_reset();
    m_q = 0; m_rl = 0; m_tc = 0; m_busy = 0; m_done = 0;
  endtask

  task automatic model_edge();
    if (!rst) begin
      model_reset();
    end else if (bus.load) begin
      m_q  = int'(bus.d);
      m_rl = int'(bus.d);
      m_tc = 0;
      m_done = (bus.d == 0);
      m_busy = (bus.d != 0);
    end else if (m_busy && bus.en) begin
      if (m_q == 1) begin
        m_tc = 1;
        if (bus.reload_en) m_q = m_rl;
        else begin
          m_q = 0; m_busy = 0; m_done = 1;
        end
      end else begin
        m_q  = m_q - 1;
        m_tc = 0;
      end
    end else begin
      m_tc = 0;
    end
  endtask

  task automatic tick(input logic en, input logic ld, input logic [W-1:0] dv,
                      input logic rl, input string tag);
    bus.en = en; bus.load = ld; bus.d = dv; bus.reload_en = rl;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    int exp2_q  [7];
    int exp2_tc [7];
    int exp4_q  [9];
    int exp4_tc [9];
    exp2_q  = '{4, 3, 2, 1, 0, 0, 0};
    exp2_tc = '{0, 0, 0, 0, 1, 0, 0};
    exp4_q  = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
    exp4_tc = '{0, 0, 1, 0, 0, 1, 0, 0, 1};

    rst = 1'b0;
    bus.en = 1'b0; bus.load = 1'b0; bus.d = '0; bus.reload_en = 1'b0;
    model_reset();
    #2;
    check_all("reset");

    // 1: release with en=1, no load -> stays idle
    @(negedge clk);
    rst = 1'b1;
    tick(1, 0, 0, 0, "t1_idle");
    tick(1, 0, 0, 0, "t1_idle");
    chk("t1_q_const", 32'(bus.q), 32'd0);

    // 2: one-shot from 5
    tick(0, 1, 5, 0, "t2_load");
    chk("t2_load_q", 32'(bus.q), 32'd5);
    for (int i = 0; i < 7; i++) begin
      tick(1, 0, 0, 0, "t2_run");
      chk("t2_q_seq",  32'(bus.q),  32'(exp2_q[i]));
      chk("t2_tc_seq", 32'(bus.tc), 32'(exp2_tc[i]));
    end
    chk("t2_done", 32'(bus.done), 32'd1);
    chk("t2_busy", 32'(bus.busy), 32'd0);

    // 3: pause holds count
    tick(1, 1, 9, 0, "t3_load");
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, "t3_run");
    chk("t3_q6", 32'(bus.q), 32'd6);
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 0, 0, "t3_pause");
      chk("t3_pause_q", 32'(bus.q), 32'd6);
      chk("t3_pause_busy", 32'(bus.busy), 32'd1);
    end
    tick(1, 0, 0, 0, "t3_resume");
    chk("t3_q5", 32'(bus.q), 32'd5);

    // 4: auto-reload period 3
    tick(0, 1, 3, 1, "t4_load");
    for (int i = 0; i < 9; i++) begin
      tick(1, 0, 0, 1, "t4_run");
      chk("t4_q_seq",  32'(bus.q),    32'(exp4_q[i]));
      chk("t4_tc_seq", 32'(bus.tc),   32'(exp4_tc[i]));
      chk("t4_done",   32'(bus.done), 32'd0);
    end

    // 5: load priority, zero load, reload after done
    tick(1, 1, 9, 0, "t5_load");
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, "t5_run");
    chk("t5_q4", 32'(bus.q), 32'd4);
    tick(1, 1, 12, 0, "t5_load12");
    chk("t5_q12", 32'(bus.q), 32'd12);
    tick(1, 1, 0, 0, "t5_load0");
    chk("t5_done0", 32'(bus.done), 32'd1);
    chk("t5_tc0", 32'(bus.tc), 32'd0);
    tick(1, 1, 15, 0, "t5_load15");
    chk("t5_busy15", 32'(bus.busy), 32'd1);
    chk("t5_done15", 32'(bus.done), 32'd0);

    // 6: asynchronous reset mid-count
    tick(1, 1, 10, 0, "t6_load");
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, "t6_run");
    chk("t6_q7", 32'(bus.q), 32'd7);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("t6_async");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, "t6_after");

    // Randomized traffic, with occasional asynchronous reset pulses
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("rnd_async");
        @(negedge clk);
        rst = 1'b1;
      end else begin
        tick(($urandom_range(0, 3) != 0),
             ($urandom_range(0, 9) == 0),
             W'($urandom),
             $urandom_range(0, 1) == 1,
             "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
